// File: rtl/cordic_gain_output.sv
// cordic_gain_output: CORDIC gain compensation (x,y * K) with a FWFT valid/ready output FIFO
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   x_in, y_in, z_in       final rotation stage results (signed), qualified by in_valid
//   x_out, y_out, z_out    FIFO head: K*x, K*y, z unchanged; qualified by out_valid
//   out_ready              consumer accepts the head this cycle
//   fifo_level             occupied FIFO entries
//   overflow               sticky flag: a result was dropped because the FIFO was full
// Build option: define CORDIC_ROUND_EN to round half-up before the shift (default truncates).
module cordic_gain_output #(
  parameter int WIDTH = 32,
  parameter int FRAC = 30,
  parameter logic [WIDTH-1:0] GAIN = 32'h26DD3B6A,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           x_in,
  input  logic [WIDTH-1:0]           y_in,
  input  logic [WIDTH-1:0]           z_in,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           x_out,
  output logic [WIDTH-1:0]           y_out,
  output logic [WIDTH-1:0]           z_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] GAIN_EXT = {{WIDTH{GAIN[WIDTH-1]}}, GAIN};
`ifdef CORDIC_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC - 1);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif
  logic signed [PW-1:0] w_xe, w_ye, r_px, r_py;
  logic [WIDTH-1:0] w_rx, w_ry;
  logic [WIDTH-1:0] r_z1, r_x2, r_y2, r_z2;
  logic r_v1, r_v2;
  logic [WIDTH-1:0] r_mx [DEPTH];
  logic [WIDTH-1:0] r_my [DEPTH];
  logic [WIDTH-1:0] r_mz [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_lvl;
  logic r_ovf;
  logic w_full, w_pop, w_wr;
  assign w_xe = {{WIDTH{x_in[WIDTH-1]}}, x_in};
  assign w_ye = {{WIDTH{y_in[WIDTH-1]}}, y_in};
  // |GAIN| < 1.0 so the scaled result always fits back into WIDTH bits
  assign w_rx = WIDTH'((r_px + RND) >>> FRAC);
  assign w_ry = WIDTH'((r_py + RND) >>> FRAC);
  assign w_full = r_lvl == (AW+1)'(DEPTH);
  assign out_valid = r_lvl != '0;
  assign w_pop = out_valid & out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the write
  assign w_wr = r_v2 & (!w_full | w_pop);
  assign x_out = r_mx[r_rp];
  assign y_out = r_my[r_rp];
  assign z_out = r_mz[r_rp];
  assign fifo_level = r_lvl;
  assign overflow = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_px <= '0;
      r_py <= '0;
      r_z1 <= '0;
      r_v1 <= 1'b0;
      r_x2 <= '0;
      r_y2 <= '0;
      r_z2 <= '0;
      r_v2 <= 1'b0;
      r_wp <= '0;
      r_rp <= '0;
      r_lvl <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mx[i] <= '0;
        r_my[i] <= '0;
        r_mz[i] <= '0;
      end
    end else begin
      r_px <= w_xe * GAIN_EXT;
      r_py <= w_ye * GAIN_EXT;
      r_z1 <= z_in;
      r_v1 <= in_valid;
      r_x2 <= w_rx;
      r_y2 <= w_ry;
      r_z2 <= r_z1;
      r_v2 <= r_v1;
      if (w_wr) begin
        r_mx[r_wp] <= r_x2;
        r_my[r_wp] <= r_y2;
        r_mz[r_wp] <= r_z2;
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_lvl <= r_lvl + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      r_ovf <= r_ovf | (r_v2 & w_full & !w_pop);
    end
  end
endmodule

// File: tb/tb_cordic_gain_output.sv
// tb_cordic_gain_output: randomized and directed checks of cordic_gain_output against a queue model
module tb_cordic_gain_output;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] x_in = '0, y_in = '0, z_in = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] x_out, y_out, z_out;
  logic out_valid, overflow;
  logic [2:0] fifo_level;
  int n_tests = 0, n_fail = 0;
  typedef struct {logic v; logic [31:0] x, y, z;} ent_t;
  ent_t d1, d2, e;
  ent_t q[$];
  logic m_ovf;
  cordic_gain_output dut (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .z_in(z_in), .in_valid(in_valid),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] kmul(input logic [31:0] a);
    longint p;
    p = longint'($signed(a)) * 64'sd652032874;
`ifdef CORDIC_ROUND_EN
    p = p + 64'sd536870912;
`endif
    p = p >>> 30;
    return p[31:0];
  endfunction
  // advance the reference one clock (results appear three edges after capture), then the DUT
  task automatic step();
    logic pop;
    if (rst) begin
      d1.v = 1'b0;
      d2.v = 1'b0;
      q.delete();
      m_ovf = 1'b0;
    end else begin
      pop = q.size() > 0 && out_ready;
      if (pop) e = q.pop_front();
      if (d2.v) begin
        if (q.size() < D) q.push_back(d2);
        else m_ovf = 1'b1;
      end
      d2 = d1;
      d1.v = in_valid;
      d1.x = kmul(x_in);
      d1.y = kmul(y_in);
      d1.z = z_in;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_tests++; if ({x_out, y_out, z_out} !== 96'd0) begin n_fail++; $display("FAIL reset_data: got %h %h %h want 0", x_out, y_out, z_out); end
  endtask
  task automatic test_directed();
    logic [31:0] want3;
`ifdef CORDIC_ROUND_EN
    want3 = 32'd2;
`else
    want3 = 32'd1;
`endif
    out_ready = 1'b1;
    x_in = 32'h40000000; y_in = 32'h0; z_in = 32'h00001234; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b want 0", out_valid); end
    step();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat3_valid: got %b want 1", out_valid); end
    n_tests++; if ({x_out, y_out, z_out} !== {32'h26DD3B6A, 32'h0, 32'h00001234}) begin n_fail++; $display("FAIL unit_gain: got %h %h %h want 26dd3b6a 0 1234", x_out, y_out, z_out); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL one_cycle_valid: got %b want 0", out_valid); end
    x_in = 32'hC0000000; y_in = 32'h40000000; z_in = 32'hABCD0000; in_valid = 1'b1;
    step();
    x_in = 32'd3; y_in = 32'd0;
    step();
    x_in = 32'd2;
    step();
    in_valid = 1'b0;
    n_tests++; if ({out_valid, x_out, y_out} !== {1'b1, 32'hD922C496, 32'h26DD3B6A}) begin n_fail++; $display("FAIL neg_gain: got %b %h %h want 1 d922c496 26dd3b6a", out_valid, x_out, y_out); end
    step();
    n_tests++; if ({out_valid, x_out} !== {1'b1, want3}) begin n_fail++; $display("FAIL round3: got %b %h want 1 %h", out_valid, x_out, want3); end
    step();
    n_tests++; if ({out_valid, x_out} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL round2: got %b %h want 1 1", out_valid, x_out); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL directed_drain: got %b want 0", out_valid); end
  endtask
  task automatic test_overflow();
    logic [31:0] xv;
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      xv = 32'(k) << 30;
      x_in = xv; y_in = $urandom; z_in = 32'(k); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      xv = 32'(k) << 30;
      n_tests++; if ({out_valid, x_out, z_out} !== {1'b1, kmul(xv), 32'(k)}) begin n_fail++; $display("FAIL ovf_pop%0d: got %b %h %h want 1 %h %h", k, out_valid, x_out, z_out, kmul(xv), k); end
      n_tests++; if (y_out !== q[0].y) begin n_fail++; $display("FAIL ovf_popy%0d: got %h want %h", k, y_out, q[0].y); end
      step();
    end
    n_tests++; if ({out_valid, fifo_level, overflow} !== {1'b0, 3'd0, 1'b1}) begin n_fail++; $display("FAIL ovf_drain: got %b %0d %b want 0 0 1", out_valid, fifo_level, overflow); end
  endtask
  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      x_in = $urandom; y_in = $urandom; z_in = $urandom; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n_tests++; if (fifo_level !== 3'd3) begin n_fail++; $display("FAIL mid_level: got %0d want 3", fifo_level); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    n_tests++; if ({out_valid, fifo_level, overflow} !== {1'b0, 3'd0, 1'b0}) begin n_fail++; $display("FAIL mid_reset: got %b %0d %b want 0 0 0", out_valid, fifo_level, overflow); end
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++; if ({out_valid, fifo_level} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL mid_ghost%0d: got %b %0d want 0 0", k, out_valid, fifo_level); end
    end
  endtask
  task automatic test_back_to_back();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 26; k++) begin
      if (k == 6) out_ready = 1'b1;
      x_in = $urandom; y_in = $urandom; z_in = $urandom;
      step();
      if (k >= 6) begin
        n_tests++; if ({out_valid, fifo_level, overflow} !== {1'b1, 3'd4, 1'b0}) begin n_fail++; $display("FAIL b2b_state%0d: got %b %0d %b want 1 4 0", k, out_valid, fifo_level, overflow); end
        n_tests++; if (q.size() == 0 || {x_out, y_out, z_out} !== {q[0].x, q[0].y, q[0].z}) begin n_fail++; $display("FAIL b2b_data%0d: got %h %h %h", k, x_out, y_out, z_out); end
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      n_tests++; if (fifo_level !== 3'(q.size()) || out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL b2b_drain%0d: got %0d want %0d", k, fifo_level, q.size()); end
      if (q.size() > 0) begin
        n_tests++; if ({x_out, y_out, z_out} !== {q[0].x, q[0].y, q[0].z}) begin n_fail++; $display("FAIL b2b_ddata%0d: got %h %h %h want %h %h %h", k, x_out, y_out, z_out, q[0].x, q[0].y, q[0].z); end
      end
    end
  endtask
  task automatic test_random();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      x_in = $urandom; y_in = $urandom; z_in = $urandom;
      if (k % 50 == 7) x_in = 32'h80000000;
      step();
      n_tests++; if (fifo_level !== 3'(q.size()) || out_valid !== (q.size() > 0) || overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_state%0d: got %b %0d %b want %b %0d %b", k, out_valid, fifo_level, overflow, q.size() > 0, q.size(), m_ovf); end
      if (q.size() > 0) begin
        n_tests++; if ({x_out, y_out, z_out} !== {q[0].x, q[0].y, q[0].z}) begin n_fail++; $display("FAIL rnd_data%0d: got %h %h %h want %h %h %h", k, x_out, y_out, z_out, q[0].x, q[0].y, q[0].z); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_overflow();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
